hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 196 +++++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// Register write-pending scoreboard for an in-order pipeline. Each tracked
// program register keeps a small counter of writes that have left decode but
// not yet retired (or been squashed). Decode stalls on any read of a register
// with pending writes, and on issue into a saturated counter. A non-AOK
// retirement stops further issue, lets in-flight work drain, then halts.
//
// Optional feature: define HAZARD_SCOREBOARD_STATS_EN to add the 32-bit
// stall_cycles output (saturating count of cycles with issue_valid & stall).

module hazard_scoreboard #(
    parameter int NREG = 15,
    parameter int CNTW = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  d_srcA,
    input  logic [3:0]  d_srcB,
    input  logic        issue_valid,
    input  logic [3:0]  issue_dstE,
    input  logic [3:0]  issue_dstM,
    input  logic        retire_valid,
    input  logic [3:0]  retire_dstE,
    input  logic [3:0]  retire_dstM,
    input  logic [0:3]  W_stat,
    input  logic        kill_valid,
    input  logic [3:0]  kill_dstE,
    input  logic [3:0]  kill_dstM,
    output logic        stall,
    output logic        issue_ok,
    output logic        halted,
    output logic [0:3]  halt_stat,
`ifdef HAZARD_SCOREBOARD_STATS_EN
    output logic [31:0] stall_cycles,
`endif
    output logic        busy_any
);

    localparam logic [CNTW-1:0] CNT_MAX = '1;

    localparam logic [0:3] STAT_AOK = 4'b1000;
    localparam logic [0:3] STAT_HLT = 4'b0100;
    localparam logic [0:3] STAT_ADR = 4'b0010;
    localparam logic [0:3] STAT_INS = 4'b0001;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t               state_reg;
    logic                 halted_reg;
    logic [0:3]           halt_stat_reg;

    // All counters packed together so a single sequential block owns them.
    logic [NREG*CNTW-1:0] cnt_reg;
    logic [NREG*CNTW-1:0] cnt_next;

    // Full 16-entry view of the counters: untracked ids (including 4'hF)
    // read as zero, so they never match "busy" or "saturated".
    logic [CNTW-1:0]      cnt_view [16];
    logic [15:0]          nz_vec;

    logic                 src_busy;
    logic                 dst_sat;
    logic [0:3]           w_norm;

    genvar gi;

    generate
        for (gi = 0; gi < 16; gi++) begin : g_view
            if (gi < NREG) begin : g_tracked
                assign cnt_view[gi] = cnt_reg[gi*CNTW +: CNTW];
            end else begin : g_untracked
                assign cnt_view[gi] = '0;
            end
            assign nz_vec[gi] = |cnt_view[gi];
        end
    endgenerate

    // Hazard detection and issue qualification, purely combinational.
    always_comb begin
        src_busy = nz_vec[d_srcA] | nz_vec[d_srcB];
        dst_sat  = issue_valid &
                   ((cnt_view[issue_dstE] == CNT_MAX) |
                    (cnt_view[issue_dstM] == CNT_MAX));
        stall    = src_busy | dst_sat;
        issue_ok = issue_valid & ~stall & (state_reg == RUN);
    end

    assign busy_any  = |nz_vec;
    assign halted    = halted_reg;
    assign halt_stat = halt_stat_reg;

    // Anything that is not a clean one-hot status is reported as INS.
    always_comb begin
        w_norm = STAT_INS;
        if ((W_stat == STAT_AOK) || (W_stat == STAT_HLT) ||
            (W_stat == STAT_ADR) || (W_stat == STAT_INS)) begin
            w_norm = W_stat;
        end
    end

    // Per-register next-count: one increment from issue, then up to one
    // decrement each from retire and kill, each clamped at zero. A matching
    // dstE/dstM pair in one instruction folds into a single event. Issue can
    // only increment a counter below CNT_MAX (saturation stalls), so the
    // increment never overflows.
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_cnt
            logic            inc;
            logic            dec_r;
            logic            dec_k;
            logic [CNTW-1:0] cur;
            logic [CNTW-1:0] after_inc;
            logic [CNTW-1:0] after_ret;
            logic [CNTW-1:0] after_kill;

            // Net change for this register from issue, retire and kill.
            always_comb begin
                cur        = cnt_reg[gi*CNTW +: CNTW];
                inc        = issue_ok &
                             ((issue_dstE == 4'(gi)) | (issue_dstM == 4'(gi)));
                dec_r      = retire_valid &
                             ((retire_dstE == 4'(gi)) | (retire_dstM == 4'(gi)));
                dec_k      = kill_valid &
                             ((kill_dstE == 4'(gi)) | (kill_dstM == 4'(gi)));
                after_inc  = inc ? cur + CNTW'(1) : cur;
                after_ret  = (dec_r && (after_inc != '0)) ?
                             after_inc - CNTW'(1) : after_inc;
                after_kill = (dec_k && (after_ret != '0)) ?
                             after_ret - CNTW'(1) : after_ret;
            end

            assign cnt_next[gi*CNTW +: CNTW] = after_kill;
        end
    endgenerate

    // Counter storage; reset wins over any same-cycle activity.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    // Run/drain/halt control with registered halted and latched status.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= RUN;
            halted_reg    <= 1'b0;
            halt_stat_reg <= STAT_AOK;
        end else begin
            case (state_reg)
                RUN: begin
                    if (retire_valid && (w_norm != STAT_AOK)) begin
                        state_reg     <= DRAIN;
                        halt_stat_reg <= w_norm;
                    end
                end
                DRAIN: begin
                    if (!busy_any) begin
                        state_reg  <= HALTED;
                        halted_reg <= 1'b1;
                    end
                end
                HALTED: begin
                    state_reg  <= HALTED;
                    halted_reg <= 1'b1;
                end
                default: begin
                    state_reg  <= RUN;
                    halted_reg <= 1'b0;
                end
            endcase
        end
    end

`ifdef HAZARD_SCOREBOARD_STATS_EN
    logic [31:0] stall_cycles_reg;

    // Saturating count of cycles where decode wanted to issue but stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_reg <= '0;
        end else if (issue_valid && stall && (stall_cycles_reg != 32'hFFFF_FFFF)) begin
            stall_cycles_reg <= stall_cycles_reg + 32'd1;
        end
    end

    assign stall_cycles = stall_cycles_reg;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard: directed scenarios followed by random
// traffic, all compared against a counter-array reference model.
// Define HAZARD_SCOREBOARD_STATS_EN to also exercise stall_cycles.

module tb_hazard_scoreboard;

    localparam int NREG = 15;
    localparam int CNTW = 2;
    localparam int MAXC = (1 << CNTW) - 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  d_srcA, d_srcB;
    logic        issue_valid;
    logic [3:0]  issue_dstE, issue_dstM;
    logic        retire_valid;
    logic [3:0]  retire_dstE, retire_dstM;
    logic [0:3]  W_stat;
    logic        kill_valid;
    logic [3:0]  kill_dstE, kill_dstM;
    logic        stall, issue_ok, halted, busy_any;
    logic [0:3]  halt_stat;
`ifdef HAZARD_SCOREBOARD_STATS_EN
    logic [31:0] stall_cycles;
`endif

    always #5 clk = ~clk;

    hazard_scoreboard #(.NREG(NREG), .CNTW(CNTW)) dut (
        .clk          (clk),
        .reset        (reset),
        .d_srcA       (d_srcA),
        .d_srcB       (d_srcB),
        .issue_valid  (issue_valid),
        .issue_dstE   (issue_dstE),
        .issue_dstM   (issue_dstM),
        .retire_valid (retire_valid),
        .retire_dstE  (retire_dstE),
        .retire_dstM  (retire_dstM),
        .W_stat       (W_stat),
        .kill_valid   (kill_valid),
        .kill_dstE    (kill_dstE),
        .kill_dstM    (kill_dstM),
        .stall        (stall),
        .issue_ok     (issue_ok),
        .halted       (halted),
        .halt_stat    (halt_stat),
`ifdef HAZARD_SCOREBOARD_STATS_EN
        .stall_cycles (stall_cycles),
`endif
        .busy_any     (busy_any)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: pending writes per id, machine mode, latched status.
    int          m_cnt [16];
    int          m_mode;     // 0 running, 1 draining, 2 halted
    logic [0:3]  m_hs;
    logic [31:0] m_sc;

    function automatic logic [0:3] norm_stat(logic [0:3] w);
        if (w == 4'b1000 || w == 4'b0100 || w == 4'b0010 || w == 4'b0001)
            return w;
        return 4'b0001;
    endfunction

    function automatic int pend(logic [3:0] id);
        if (int'(id) >= NREG) return 0;
        return m_cnt[id];
    endfunction

    function automatic bit m_stall();
        bit s;
        s = (pend(d_srcA) != 0) || (pend(d_srcB) != 0);
        if (issue_valid && ((pend(issue_dstE) == MAXC) || (pend(issue_dstM) == MAXC)))
            s = 1'b1;
        return s;
    endfunction

    function automatic bit m_ok();
        return issue_valid && !m_stall() && (m_mode == 0);
    endfunction

    function automatic bit m_busy();
        for (int r = 0; r < NREG; r++) if (m_cnt[r] != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 16; r++) m_cnt[r] = 0;
        m_mode = 0;
        m_hs   = 4'b1000;
        m_sc   = 32'd0;
    endtask

    // Apply the clock edge to the model using the inputs held across it.
    task automatic model_clock();
        bit ok, st, was_busy;
        int n;
        if (reset) begin
            model_reset();
            return;
        end
        ok       = m_ok();
        st       = m_stall();
        was_busy = m_busy();
        if (issue_valid && st && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
        for (int r = 0; r < NREG; r++) begin
            n = m_cnt[r];
            if (ok && (int'(issue_dstE) == r || int'(issue_dstM) == r)) n++;
            if (retire_valid && (int'(retire_dstE) == r || int'(retire_dstM) == r) && n > 0) n--;
            if (kill_valid && (int'(kill_dstE) == r || int'(kill_dstM) == r) && n > 0) n--;
            m_cnt[r] = n;
        end
        if (m_mode == 0 && retire_valid && norm_stat(W_stat) != 4'b1000) begin
            m_mode = 1;
            m_hs   = norm_stat(W_stat);
        end else if (m_mode == 1 && !was_busy) begin
            m_mode = 2;
        end
    endtask

    // One clock with the currently driven inputs; called at posedge+1.
    task automatic step();
        #1;
        chk("stall", 32'(stall), 32'(m_stall()));
        chk("issue_ok", 32'(issue_ok), 32'(m_ok()));
        @(posedge clk);
        model_clock();
        #1;
        chk("halted", 32'(halted), 32'(m_mode == 2));
        chk("halt_stat", 32'(halt_stat), 32'(m_hs));
        chk("busy_any", 32'(busy_any), 32'(m_busy()));
`ifdef HAZARD_SCOREBOARD_STATS_EN
        chk("stall_cycles", stall_cycles, m_sc);
`endif
    endtask

    task automatic idle();
        reset        = 1'b0;
        d_srcA       = 4'hF;  d_srcB      = 4'hF;
        issue_valid  = 1'b0;  issue_dstE  = 4'hF; issue_dstM  = 4'hF;
        retire_valid = 1'b0;  retire_dstE = 4'hF; retire_dstM = 4'hF;
        W_stat       = 4'b1000;
        kill_valid   = 1'b0;  kill_dstE   = 4'hF; kill_dstM   = 4'hF;
    endtask

    function automatic logic [3:0] rid();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6) return 4'(r);
        if (r < 8) return 4'hF;
        return 4'($urandom_range(6, 15));
    endfunction

    initial begin
        idle();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        model_reset();

        // Reset state
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_halt_stat", 32'(halt_stat), 32'h8);
        chk("rst_busy", 32'(busy_any), 32'd0);
        idle();
        step();

        // RAW hazard on r3, cleared by retirement
        issue_valid = 1'b1; issue_dstE = 4'd3;
        step();
        idle(); d_srcA = 4'd3;
        #1 chk("raw_stall_set", 32'(stall), 32'd1);
        step();
        retire_valid = 1'b1; retire_dstE = 4'd3;
        step();
        idle(); d_srcA = 4'd3;
        #1 chk("raw_stall_clear", 32'(stall), 32'd0);
        step();

        // Saturation of r5 after three pending writes
        idle(); issue_valid = 1'b1; issue_dstE = 4'd5;
        for (int i = 0; i < 3; i++) begin
            #1 chk("sat_fill_ok", 32'(issue_ok), 32'd1);
            step();
        end
        #1 chk("sat_stall", 32'(stall), 32'd1);
        chk("sat_issue_ok", 32'(issue_ok), 32'd0);
        step();
        idle(); retire_valid = 1'b1; retire_dstE = 4'd5; retire_dstM = 4'd5;
        for (int i = 0; i < 3; i++) step();
        idle();
        #1 chk("sat_drained", 32'(busy_any), 32'd0);
        step();

        // Same-cycle issue and retire on r2, then kill via dstM
        idle(); issue_valid = 1'b1; issue_dstE = 4'd2;
        step();
        retire_valid = 1'b1; retire_dstE = 4'd2;
        step();
        idle(); d_srcB = 4'd2;
        #1 chk("net_zero_stall", 32'(stall), 32'd1);
        step();
        idle(); kill_valid = 1'b1; kill_dstM = 4'd2;
        step();
        idle(); d_srcB = 4'd2;
        #1 chk("kill_clear", 32'(stall), 32'd0);
        chk("kill_busy", 32'(busy_any), 32'd0);
        step();

        // HLT retirement with one write pending: drain, then halt
        idle(); issue_valid = 1'b1; issue_dstE = 4'd1;
        step();
        idle(); retire_valid = 1'b1; W_stat = 4'b0100;
        step();
        idle(); issue_valid = 1'b1; issue_dstE = 4'd9;
        #1 chk("drain_issue_ok", 32'(issue_ok), 32'd0);
        step();
        idle(); retire_valid = 1'b1; retire_dstE = 4'd1;
        step();
        idle();
        step();
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_stat_hlt", 32'(halt_stat), 32'h4);
        idle(); retire_valid = 1'b1; W_stat = 4'b0010;
        step();
        chk("halt_first_wins", 32'(halt_stat), 32'h4);

        // Reset in DRAIN with counters nonzero and traffic present
        idle(); reset = 1'b1;
        step();
        idle(); issue_valid = 1'b1; issue_dstE = 4'd7;
        step(); step();
        idle(); retire_valid = 1'b1; W_stat = 4'b0110;
        step();
        chk("bad_stat_ins", 32'(halt_stat), 32'h1);
        idle(); reset = 1'b1; issue_valid = 1'b1; issue_dstE = 4'd8;
        retire_valid = 1'b1; retire_dstE = 4'd7; kill_valid = 1'b1; kill_dstE = 4'd7;
        step();
        chk("rst_drain_halted", 32'(halted), 32'd0);
        chk("rst_drain_busy", 32'(busy_any), 32'd0);
        idle(); issue_valid = 1'b1; issue_dstE = 4'd8;
        #1 chk("rst_drain_run", 32'(issue_ok), 32'd1);
        step();

`ifdef HAZARD_SCOREBOARD_STATS_EN
        // Seven stalled issue attempts
        idle(); reset = 1'b1;
        step();
        idle(); issue_valid = 1'b1; issue_dstE = 4'd6;
        step();
        idle(); issue_valid = 1'b1; d_srcA = 4'd6;
        for (int i = 0; i < 7; i++) step();
        chk("stats_seven", stall_cycles, 32'd7);
`endif

        // Random traffic against the model
        idle(); reset = 1'b1;
        step();
        for (int i = 0; i < 2500; i++) begin
            reset        = ($urandom_range(0, 79) == 0);
            d_srcA       = rid();
            d_srcB       = rid();
            issue_valid  = $urandom_range(0, 1) == 1;
            issue_dstE   = rid();
            issue_dstM   = ($urandom_range(0, 3) == 0) ? issue_dstE : rid();
            retire_valid = $urandom_range(0, 2) != 0;
            retire_dstE  = rid();
            retire_dstM  = ($urandom_range(0, 3) == 0) ? retire_dstE : rid();
            W_stat       = ($urandom_range(0, 39) == 0) ? 4'($urandom) : 4'b1000;
            kill_valid   = $urandom_range(0, 4) == 0;
            kill_dstE    = rid();
            kill_dstM    = rid();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
